// File: rtl/fp_round_pack_if.sv
// Handshake and operand/result bundle between the normalize stage, the round/pack block and its consumer.
interface fp_round_pack_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   norm_sign;
    logic [EXP_W-1:0]       norm_exp;
    logic [MAN_W-1:0]       norm_man;
    logic                   guard;
    logic                   round_b;
    logic                   sticky;
    logic                   in_zero;
    logic                   in_inf;
    logic                   in_nan;
    logic                   out_valid;
    logic                   out_ready;
    logic [EXP_W+MAN_W:0]   result;
    logic                   overflow;
    logic                   inexact;

    modport slave (
        input  in_valid, norm_sign, norm_exp, norm_man, guard, round_b, sticky,
               in_zero, in_inf, in_nan, out_ready,
        output in_ready, out_valid, result, overflow, inexact
    );

    modport master (
        output in_valid, norm_sign, norm_exp, norm_man, guard, round_b, sticky,
               in_zero, in_inf, in_nan, out_ready,
        input  in_ready, out_valid, result, overflow, inexact
    );
endinterface

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and IEEE-754 pack, two-stage valid/ready pipeline.
// Optional FP_ROUND_STATS_EN adds a saturating count of rounded-up finite operands.
module fp_round_pack #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_round_pack_if.slave       bus
`ifdef FP_ROUND_STATS_EN
    ,
    output logic [15:0]          rnd_count
`endif
);
    localparam int FW = EXP_W + MAN_W;

    function automatic logic calc_round_up(input logic g, input logic r,
                                           input logic s, input logic lsb);
        return g & (r | s | lsb);
    endfunction

    // Mantissa carry ripples into the exponent, which also handles denormal -> normal.
    function automatic logic [FW-1:0] round_inc(input logic [FW-1:0] mag, input logic up);
        return mag + {{(FW-1){1'b0}}, up};
    endfunction

    logic             is_nan, is_inf, is_zero;
    logic             round_up;
    logic [FW-1:0]    rounded;
    logic             sign_d, ovf_d, inx_d;
    logic [EXP_W-1:0] exp_d;
    logic [MAN_W-1:0] man_d;

    logic             vld_p1, sign_p1, ovf_p1, inx_p1;
    logic [EXP_W-1:0] exp_p1;
    logic [MAN_W-1:0] man_p1;
    logic             vld_p2, ovf_p2, inx_p2;
    logic [FW:0]      result_p2;

    logic             load_p1, adv_p2;

    assign adv_p2       = vld_p1 & (~vld_p2 | bus.out_ready);
    assign bus.in_ready = ~vld_p1 | adv_p2;
    assign load_p1      = bus.in_valid & bus.in_ready;

    always_comb begin
        is_nan   = bus.in_nan;
        is_inf   = ~is_nan & (bus.in_inf | ((&bus.norm_exp) & ~bus.in_zero));
        is_zero  = ~is_nan & ~is_inf & bus.in_zero;
        round_up = calc_round_up(bus.guard, bus.round_b, bus.sticky, bus.norm_man[0]);
        rounded  = round_inc({bus.norm_exp, bus.norm_man}, round_up);

        sign_d = bus.norm_sign;
        exp_d  = rounded[FW-1:MAN_W];
        man_d  = rounded[MAN_W-1:0];
        ovf_d  = 1'b0;
        inx_d  = bus.guard | bus.round_b | bus.sticky;
        if (is_nan) begin
            sign_d = 1'b0;
            exp_d  = '1;
            man_d  = {1'b1, {(MAN_W-1){1'b0}}};
            inx_d  = 1'b0;
        end else if (is_inf) begin
            exp_d  = '1;
            man_d  = '0;
            inx_d  = 1'b0;
        end else if (is_zero) begin
            exp_d  = '0;
            man_d  = '0;
            inx_d  = 1'b0;
        end else if (&rounded[FW-1:MAN_W]) begin
            man_d  = '0;
            ovf_d  = 1'b1;
            inx_d  = 1'b1;
        end
    end

    // Stage 1: rounded fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else if (load_p1) begin
            vld_p1 <= 1'b1;
        end else if (adv_p2) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load_p1) begin
            sign_p1 <= sign_d;
            exp_p1  <= exp_d;
            man_p1  <= man_d;
            ovf_p1  <= ovf_d;
            inx_p1  <= inx_d;
        end
    end

    // Stage 2: packed result, held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2    <= 1'b0;
            result_p2 <= '0;
            ovf_p2    <= 1'b0;
            inx_p2    <= 1'b0;
        end else begin
            if (adv_p2) begin
                vld_p2    <= 1'b1;
                result_p2 <= {sign_p1, exp_p1, man_p1};
                ovf_p2    <= ovf_p1;
                inx_p2    <= inx_p1;
            end else if (bus.out_ready) begin
                vld_p2    <= 1'b0;
            end
        end
    end

    assign bus.out_valid = vld_p2;
    assign bus.result    = result_p2;
    assign bus.overflow  = ovf_p2;
    assign bus.inexact   = inx_p2;

`ifdef FP_ROUND_STATS_EN
    logic finite;
    assign finite = ~is_nan & ~is_inf & ~is_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_count <= '0;
        end else if (load_p1 && round_up && finite && rnd_count != 16'hFFFF) begin
            rnd_count <= rnd_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fp_round_pack.sv
// Bench for fp_round_pack: directed corner cases, backpressure, reset flush and random traffic vs. a numeric model.
module tb_fp_round_pack;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_round_pack_if #(.EXP_W(8), .MAN_W(23)) bus ();
    fp_round_pack #(.EXP_W(8), .MAN_W(23)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int ncmp = 0;
    int nerr = 0;
    logic [33:0] exp_q[$];

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        ncmp++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        check(tag, {33'd0, obs}, {33'd0, expv});
    endtask

    // {overflow, inexact, result} computed from the value-level rounding rules
    function automatic logic [33:0] model(input logic s, input logic [7:0] e, input logic [22:0] m,
                                          input logic g, input logic r, input logic st,
                                          input logic z, input logic i, input logic n);
        int unsigned mi;
        int unsigned ei;
        logic inx;
        if (n) return {2'b00, 32'h7FC00000};
        if (i || (e == 8'hFF && !z)) return {2'b00, s, 8'hFF, 23'd0};
        if (z) return {2'b00, s, 31'd0};
        mi = m;
        ei = e;
        if (g && (r || st || (m % 2 == 1))) mi = mi + 1;
        if (mi == (1 << 23)) begin
            mi = 0;
            ei = ei + 1;
        end
        inx = g | r | st;
        if (ei == 255) return {2'b11, s, 8'hFF, 23'd0};
        return {1'b0, inx, s, ei[7:0], mi[22:0]};
    endfunction

    function automatic logic [33:0] model_now();
        return model(bus.norm_sign, bus.norm_exp, bus.norm_man, bus.guard, bus.round_b,
                     bus.sticky, bus.in_zero, bus.in_inf, bus.in_nan);
    endfunction

    function automatic logic [33:0] observed();
        return {bus.overflow, bus.inexact, bus.result};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    ncmp++;
                    nerr++;
                    $error("FAIL extra_output observed=%h expected=none", observed());
                end else begin
                    check("stream", observed(), exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) exp_q.push_back(model_now());
        end
    end

    task automatic drive(input logic s, input logic [7:0] e, input logic [22:0] m,
                         input logic [2:0] grs, input logic z, input logic i, input logic n);
        bus.norm_sign = s;
        bus.norm_exp  = e;
        bus.norm_man  = m;
        {bus.guard, bus.round_b, bus.sticky} = grs;
        bus.in_zero = z;
        bus.in_inf  = i;
        bus.in_nan  = n;
    endtask

    task automatic directed(input string tag, input logic s, input logic [7:0] e, input logic [22:0] m,
                            input logic [2:0] grs, input logic z, input logic i, input logic n,
                            input logic [31:0] er, input logic eo, input logic ei);
        drive(s, e, m, grs, z, i, n);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        check1({tag, "_rdy"}, bus.in_ready, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check1({tag, "_lat1"}, bus.out_valid, 1'b0);
        @(posedge clk); #1;
        check1({tag, "_lat2"}, bus.out_valid, 1'b1);
        check({tag, "_val"}, observed(), {eo, ei, er});
    endtask

    task automatic drain(input string tag);
        int k = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        check(tag, 34'(exp_q.size()), 34'd0);
    endtask

    initial begin
        logic [33:0] ea;
        logic [7:0]  re;
        logic [22:0] rm;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 8'h00, 23'd0, 3'b000, 1'b0, 1'b0, 1'b0);

        #3;
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", observed(), 34'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 check1("rst_in_ready", bus.in_ready, 1'b1);

        directed("one",        1'b0, 8'h7F, 23'h000000, 3'b000, 1'b0, 1'b0, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        directed("tie_odd",    1'b0, 8'h7F, 23'h000001, 3'b100, 1'b0, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b1);
        directed("tie_even",   1'b0, 8'h7F, 23'h000002, 3'b100, 1'b0, 1'b0, 1'b0, 32'h3F800002, 1'b0, 1'b1);
        directed("carry",      1'b0, 8'h7F, 23'h7FFFFF, 3'b110, 1'b0, 1'b0, 1'b0, 32'h40000000, 1'b0, 1'b1);
        directed("denorm",     1'b0, 8'h00, 23'h7FFFFF, 3'b101, 1'b0, 1'b0, 1'b0, 32'h00800000, 1'b0, 1'b1);
        directed("ovf",        1'b0, 8'hFE, 23'h7FFFFF, 3'b101, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b1, 1'b1);
        directed("nan",        1'b1, 8'h12, 23'h000123, 3'b111, 1'b0, 1'b0, 1'b1, 32'h7FC00000, 1'b0, 1'b0);
        directed("inf_neg",    1'b1, 8'h40, 23'h000001, 3'b111, 1'b1, 1'b1, 1'b0, 32'hFF800000, 1'b0, 1'b0);
        directed("zero_neg",   1'b1, 8'h40, 23'h000001, 3'b111, 1'b1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b0);
        directed("exp_ff",     1'b0, 8'hFF, 23'h000055, 3'b110, 1'b0, 1'b0, 1'b0, 32'h7F800000, 1'b0, 1'b0);
        directed("down_trunc", 1'b1, 8'h81, 23'h123457, 3'b011, 1'b0, 1'b0, 1'b0, 32'hC0923457, 1'b0, 1'b1);
        drain("drain_directed");

        // Backpressure: two operands fill the pipe, the third waits
        bus.out_ready = 1'b0;
        drive(1'b0, 8'h80, 23'h123456, 3'b100, 1'b0, 1'b0, 1'b0);
        ea = model_now();
        bus.in_valid = 1'b1;
        check1("bp_rdy_a", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 8'h81, 23'h000003, 3'b100, 1'b0, 1'b0, 1'b0);
        check1("bp_rdy_b", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 8'h7E, 23'h7FFFFF, 3'b111, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check1("bp_stall_rdy", bus.in_ready, 1'b0);
            check1("bp_hold_vld", bus.out_valid, 1'b1);
            check("bp_hold_val", observed(), ea);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        #1 check1("bp_release_rdy", bus.in_ready, 1'b1);
        @(posedge clk); #1;
        drain("bp_drain");

        // Random traffic with random stalls on both sides
        for (int v = 0; v < 300; v++) begin
            case ($urandom_range(0, 5))
                0: re = 8'h00;
                1: re = 8'h01;
                2: re = 8'h7F;
                3: re = 8'hFE;
                4: re = 8'hFF;
                default: re = 8'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: rm = 23'h000000;
                1: rm = 23'h7FFFFF;
                default: rm = 23'($urandom);
            endcase
            drive(1'($urandom), re, rm, 3'($urandom),
                  ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 15) == 0));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        drain("rand_drain");

        // Reset with two operands in flight
        drive(1'b0, 8'h90, 23'h000010, 3'b000, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 8'h91, 23'h000011, 3'b000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check1("flight_vld", bus.out_valid, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check1("mid_rst_vld", bus.out_valid, 1'b0);
        check("mid_rst_val", observed(), 34'd0);
        exp_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check1("post_rst_idle", bus.out_valid, 1'b0);
        end
        directed("post_rst", 1'b1, 8'h7F, 23'h000000, 3'b000, 1'b0, 1'b0, 1'b0, 32'hBF800000, 1'b0, 1'b0);
        drain("final_drain");

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule
